regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between the in-order pipeline writeback and N_AUX long-latency requesters (mult/div unit, uncached load return, inter-core mailbox).
- Keeps a 32-bit pending-write scoreboard, so decode can stall on registers whose long-latency result has not yet landed.
- Sits between the WB stage / aux units and the register file write inputs (WriteRegister, WriteData, RegWrite).

Parameters:
- N_AUX, 2, number of auxiliary write requesters (1..4)
- MAX_WAIT, 4, cycles an aux request may be blocked by WB before WB is stalled

Ports:
- Clk  in  1  clock; all state on rising edge
- Reset  in  1  synchronous, active-high reset
- wb_valid  in  1  pipeline writeback wants the port this cycle
- wb_reg  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- wb_stall  out  1  WB is blocked this cycle; pipeline must hold MEM/WB
- aux_req  in  N_AUX  aux write request, held until granted
- aux_reg  in  5*N_AUX  aux destination registers, packed, index i at [5i+4:5i]
- aux_data  in  32*N_AUX  aux write data, packed
- aux_grant  out  N_AUX  one-hot; request i is consumed this cycle
- sb_set  in  1  long-latency op issued; mark sb_set_reg pending
- sb_set_reg  in  5  destination of the issued op
- rs, rt  in  5 each  decode source registers
- rs_busy, rt_busy  out  1 each  source has a pending aux write
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  5  register file write address (registered)
- rf_wdata  out  32  register file write data (registered)

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, scoreboard all 0, wait counter 0, round-robin pointer 0. aux_grant and wb_stall are combinational and evaluate to 0 while Reset=1.
- Arbitration is combinational in cycle t; the winner's write is registered onto rf_* and lands in the register file at edge t+2. Write latency is 1 cycle to rf_*.
- Priority: WB wins when wb_valid=1 and starve=0. Otherwise the aux winner is chosen round-robin, starting at the pointer.
- After each aux grant, the pointer moves to (granted index + 1) mod N_AUX.
- Starvation counter counts cycles in which any aux_req=1 but no aux grant occurs. It saturates at MAX_WAIT. starve = (counter == MAX_WAIT).
- When starve=1 and wb_valid=1: wb_stall=1 and the aux winner is granted. The counter clears on any aux grant.
- wb_stall=0 whenever wb_valid=0 or WB wins.
- Exactly one of {WB, one aux} writes per cycle. aux_grant has at most one bit set.
- Writes to register 0 are accepted (grant / no stall) but produce rf_we=0.
- Scoreboard:
  - The bit for a register clears on the cycle its aux grant is issued.
  - sb_set sets bit sb_set_reg next edge. Register 0 is never set.
  - sb_set and an aux-grant clear on the same register in the same cycle: set wins.
  - WB writes never touch the scoreboard.
- rs_busy = pending[rs], rt_busy = pending[rt], combinational, and always 0 for register 0.
- An aux_req for a register whose bit is not set is still arbitrated and written; no error is raised.
- Reset mid-operation: in-flight registered write is dropped (rf_we=0 next cycle) and all pending bits clear. Requesters must re-issue.

Optional Feature:
- Macro REGFILE_ARB_BYPASS_EN.
- Defined: adds outputs rs_fwd_hit, rt_fwd_hit (1 bit) and rs_fwd_data, rt_fwd_data (32 bits). A hit occurs when rf_we=1 and rf_waddr equals rs/rt (nonzero); fwd_data=rf_wdata. This covers the register file's write-then-read gap.
- Not defined: ports absent; the register file read value is used unmodified.

Decomposition:
- Shared package regfile_arb_pkg: REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, ZERO_REG=0.
- One sub-module: rr_arbiter (N-input round-robin, combinational grant plus registered pointer).

Test Plan:
1. wb_valid=1 reg 8 data 0xDEADBEEF, no aux -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF; wb_stall=0.
2. aux_req=2'b11 (regs 3, 4), wb_valid=0 -> grants 01 then 10 in consecutive cycles; rf_waddr 3 then 4.
3. wb_valid held 1, aux_req[0] held 1 with MAX_WAIT=4 -> WB wins 4 cycles; cycle 5 wb_stall=1 and aux_grant=01; counter back to 0.
4. sb_set reg 9; rs=9 -> rs_busy=1 next cycle; aux grant to reg 9 -> rs_busy=0 the cycle after. Simultaneous set+clear on 9 -> stays 1.
5. wb_valid reg 0 data 0x1234 -> wb_stall=0, rf_we=0; sb_set reg 0 -> rs=0 gives rs_busy=0.
6. Reset asserted while aux grant pending and pending bits set -> next cycle rf_we=0 and all *_busy=0. With REGFILE_ARB_BYPASS_EN: write reg 5=0xA5A5A5A5, rs=5 -> rs_fwd_hit=1, rs_fwd_data=0xA5A5A5A5 for that cycle.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared widths and constants for the register file write arbiter.
package regfile_arb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
   // Pointer width covers up to four aux requesters.
   localparam int AUX_IDX_W  = 2;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// N-input round-robin arbiter: combinational one-hot grant, registered pointer.
module rr_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] grant
);

   logic [AUX_IDX_W-1:0] ptr_q, ptr_d;
   logic                 found;
   int                   idx;

   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_q) + k) % N;
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_d      = AUX_IDX_W'((idx + 1) % N);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between WB and aux requesters, with a pending-write scoreboard.
// Build option: REGFILE_ARB_BYPASS_EN adds forwarding outputs from the registered write.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int N_AUX    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        wb_valid,
   input  logic [REG_ADDR_W-1:0]       wb_reg,
   input  logic [DATA_W-1:0]           wb_data,
   output logic                        wb_stall,
   input  logic [N_AUX-1:0]            aux_req,
   input  logic [REG_ADDR_W*N_AUX-1:0] aux_reg,
   input  logic [DATA_W*N_AUX-1:0]     aux_data,
   output logic [N_AUX-1:0]            aux_grant,
   input  logic                        sb_set,
   input  logic [REG_ADDR_W-1:0]       sb_set_reg,
   input  logic [REG_ADDR_W-1:0]       rs,
   input  logic [REG_ADDR_W-1:0]       rt,
   output logic                        rs_busy,
   output logic                        rt_busy,
`ifdef REGFILE_ARB_BYPASS_EN
   output logic                        rs_fwd_hit,
   output logic                        rt_fwd_hit,
   output logic [DATA_W-1:0]           rs_fwd_data,
   output logic [DATA_W-1:0]           rt_fwd_data,
`endif
   output logic                        rf_we,
   output logic [REG_ADDR_W-1:0]       rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic [NUM_REGS-1:0]   pend_q, pend_d;
   logic                  rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
   logic                  aux_any, starve, wb_win, aux_en, grant_vld;
   logic [REG_ADDR_W-1:0] aux_sel_reg;
   logic [DATA_W-1:0]     aux_sel_data;

   // Stalling WB only makes sense if there is an aux request to let through.
   assign aux_any   = |aux_req;
   assign starve    = (wait_cnt_q == CNT_W'(MAX_WAIT));
   assign wb_win    = wb_valid && !(starve && aux_any);
   assign aux_en    = !Reset && !wb_win;
   assign wb_stall  = !Reset && wb_valid && !wb_win;
   assign grant_vld = |aux_grant;

   rr_arbiter #(.N(N_AUX)) u_rr (
      .clk   (Clk),
      .reset (Reset),
      .req   (aux_req),
      .en    (aux_en),
      .grant (aux_grant)
   );

   always_comb begin
      aux_sel_reg  = ZERO_REG;
      aux_sel_data = '0;
      for (int i = 0; i < N_AUX; i++) begin
         if (aux_grant[i]) begin
            aux_sel_reg  = aux_reg[REG_ADDR_W*i +: REG_ADDR_W];
            aux_sel_data = aux_data[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (wb_win) begin
         rf_we_d    = (wb_reg != ZERO_REG);
         rf_waddr_d = wb_reg;
         rf_wdata_d = wb_data;
      end else if (grant_vld) begin
         rf_we_d    = (aux_sel_reg != ZERO_REG);
         rf_waddr_d = aux_sel_reg;
         rf_wdata_d = aux_sel_data;
      end
   end

   // Clear before set so an issue on the same register keeps it pending.
   always_comb begin
      pend_d = pend_q;
      if (grant_vld) pend_d[aux_sel_reg] = 1'b0;
      if (sb_set && sb_set_reg != ZERO_REG) pend_d[sb_set_reg] = 1'b1;
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (grant_vld)            wait_cnt_d = '0;
      else if (aux_any && !starve) wait_cnt_d = wait_cnt_q + 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         pend_q     <= '0;
         wait_cnt_q <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         pend_q     <= pend_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign rs_busy  = (rs != ZERO_REG) && pend_q[rs];
   assign rt_busy  = (rt != ZERO_REG) && pend_q[rt];

`ifdef REGFILE_ARB_BYPASS_EN
   assign rs_fwd_hit  = rf_we_q && (rs != ZERO_REG) && (rf_waddr_q == rs);
   assign rt_fwd_hit  = rf_we_q && (rt != ZERO_REG) && (rf_waddr_q == rt);
   assign rs_fwd_data = rf_wdata_q;
   assign rt_fwd_data = rf_wdata_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table, directed corner sequences, random vs. model.
module tb_regfile_write_arbiter;
   localparam int N = 2;
   localparam int MW = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        wb_stall;
   logic [N-1:0] aux_req;
   logic [5*N-1:0] aux_reg;
   logic [32*N-1:0] aux_data;
   logic [N-1:0] aux_grant;
   logic        sb_set;
   logic [4:0]  sb_set_reg, rs, rt;
   logic        rs_busy, rt_busy, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
`ifdef REGFILE_ARB_BYPASS_EN
   logic        rs_fwd_hit, rt_fwd_hit;
   logic [31:0] rs_fwd_data, rt_fwd_data;
`endif

   regfile_write_arbiter #(.N_AUX(N), .MAX_WAIT(MW)) dut (
      .Clk(Clk), .Reset(Reset),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
      .aux_req(aux_req), .aux_reg(aux_reg), .aux_data(aux_data), .aux_grant(aux_grant),
      .sb_set(sb_set), .sb_set_reg(sb_set_reg), .rs(rs), .rt(rt),
      .rs_busy(rs_busy), .rt_busy(rt_busy),
`ifdef REGFILE_ARB_BYPASS_EN
      .rs_fwd_hit(rs_fwd_hit), .rt_fwd_hit(rt_fwd_hit),
      .rs_fwd_data(rs_fwd_data), .rt_fwd_data(rt_fwd_data),
`endif
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad = 0;

   // Reference model state
   bit        m_pend [32];
   int        m_cnt, m_ptr;
   bit        m_we, m_last_rst;
   bit [4:0]  m_addr;
   bit [31:0] m_data;
   int        e_win;
   bit        e_wbw;
   bit [N-1:0] e_grant;
   bit        e_stall;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_cnt = 0; m_ptr = 0; m_we = 0; m_addr = 0; m_data = 0; m_last_rst = 1;
   endtask

   // Called just after inputs change (at negedge); checks combinational outputs.
   task automatic pre_phase();
      bit starve;
      #1;
      starve = (m_cnt == MW);
      e_win = -1;
      e_wbw = 0;
      if (!Reset) begin
         e_wbw = wb_valid && !(starve && (aux_req != 0));
         if (!e_wbw)
            for (int k = 0; k < N; k++)
               if (e_win < 0 && aux_req[(m_ptr + k) % N]) e_win = (m_ptr + k) % N;
      end
      e_grant = (e_win >= 0) ? N'(1 << e_win) : '0;
      e_stall = !Reset && wb_valid && !e_wbw;
      chk("m_grant", 32'(aux_grant), 32'(e_grant));
      chk("m_stall", 32'(wb_stall), 32'(e_stall));
      chk("m_rs_busy", 32'(rs_busy), 32'(rs != 0 && m_pend[rs]));
      chk("m_rt_busy", 32'(rt_busy), 32'(rt != 0 && m_pend[rt]));
`ifdef REGFILE_ARB_BYPASS_EN
      chk("m_rs_hit", 32'(rs_fwd_hit), 32'(m_we && rs != 0 && m_addr == rs));
      chk("m_rt_hit", 32'(rt_fwd_hit), 32'(m_we && rt != 0 && m_addr == rt));
      if (m_we && rs != 0 && m_addr == rs) chk("m_rs_fwd", rs_fwd_data, m_data);
      if (m_we && rt != 0 && m_addr == rt) chk("m_rt_fwd", rt_fwd_data, m_data);
`endif
   endtask

   // Advances the model across the clock edge, checks registered outputs, returns at negedge.
   task automatic post_phase();
      bit [4:0] r;
      if (Reset) model_reset();
      else begin
         m_last_rst = 0;
         m_we = 0;
         if (e_wbw) begin
            m_we = (wb_reg != 0); m_addr = wb_reg; m_data = wb_data;
         end else if (e_win >= 0) begin
            r = aux_reg[5*e_win +: 5];
            m_we = (r != 0); m_addr = r; m_data = aux_data[32*e_win +: 32];
            m_pend[r] = 1'b0;
         end
         if (sb_set && sb_set_reg != 0) m_pend[sb_set_reg] = 1'b1;
         if (e_win >= 0) begin
            m_cnt = 0; m_ptr = (e_win + 1) % N;
         end else if (aux_req != 0 && m_cnt < MW) m_cnt++;
      end
      @(posedge Clk); #1;
      chk("m_rf_we", 32'(rf_we), 32'(m_we));
      if (m_we || m_last_rst) begin
         chk("m_rf_waddr", 32'(rf_waddr), 32'(m_addr));
         chk("m_rf_wdata", rf_wdata, m_data);
      end
      @(negedge Clk);
   endtask

   task automatic idle_inputs();
      Reset = 0; wb_valid = 0; wb_reg = 0; wb_data = 0; aux_req = 0;
      sb_set = 0; sb_set_reg = 0; rs = 0; rt = 0;
   endtask

   typedef struct {
      logic wbv; logic [4:0] wbr; logic [31:0] wbd; logic [1:0] areq;
      logic sbs; logic [4:0] sbr; logic [4:0] rs;
      logic [1:0] eg; logic es; logic eb; logic ewe; logic [4:0] ea; logic [31:0] ed;
   } vec_t;
   vec_t vecs[12];

   initial begin
      idle_inputs();
      aux_reg  = {5'd4, 5'd3};
      aux_data = {32'hBBBB0004, 32'hAAAA0003};
      model_reset();
      @(negedge Clk);
      Reset = 1;
      pre_phase(); post_phase();
      pre_phase(); post_phase();
      chk("rst_rf_we", 32'(rf_we), 0);
      chk("rst_rf_waddr", 32'(rf_waddr), 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      Reset = 0;

      //            wbv wbr  wbd           areq  sbs sbr rs  eg    es eb ewe ea  ed
      vecs[0]  = '{1, 8, 32'hDEADBEEF, 2'b00, 0, 0, 0, 2'b00, 0, 0, 1, 8, 32'hDEADBEEF};
      vecs[1]  = '{0, 0, 32'h0,        2'b11, 0, 0, 0, 2'b01, 0, 0, 1, 3, 32'hAAAA0003};
      vecs[2]  = '{0, 0, 32'h0,        2'b10, 0, 0, 0, 2'b10, 0, 0, 1, 4, 32'hBBBB0004};
      vecs[3]  = '{1, 8, 32'h11111111, 2'b01, 0, 0, 0, 2'b00, 0, 0, 1, 8, 32'h11111111};
      vecs[4]  = vecs[3];
      vecs[5]  = vecs[3];
      vecs[6]  = vecs[3];
      vecs[7]  = '{1, 8, 32'h11111111, 2'b01, 0, 0, 0, 2'b01, 1, 0, 1, 3, 32'hAAAA0003};
      vecs[8]  = '{1, 0, 32'h00001234, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0};
      vecs[9]  = '{0, 0, 32'h0,        2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0};
      vecs[10] = '{0, 0, 32'h0,        2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0};
      vecs[11] = '{0, 0, 32'h0,        2'b01, 0, 0, 0, 2'b01, 0, 0, 1, 3, 32'hAAAA0003};

      foreach (vecs[i]) begin
         wb_valid = vecs[i].wbv; wb_reg = vecs[i].wbr; wb_data = vecs[i].wbd;
         aux_req = vecs[i].areq; sb_set = vecs[i].sbs; sb_set_reg = vecs[i].sbr;
         rs = vecs[i].rs; rt = 0;
         pre_phase();
         chk($sformatf("v%0d_grant", i), 32'(aux_grant), 32'(vecs[i].eg));
         chk($sformatf("v%0d_stall", i), 32'(wb_stall), 32'(vecs[i].es));
         chk($sformatf("v%0d_busy", i), 32'(rs_busy), 32'(vecs[i].eb));
         post_phase();
         chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].ewe));
         if (vecs[i].ewe) begin
            chk($sformatf("v%0d_addr", i), 32'(rf_waddr), 32'(vecs[i].ea));
            chk($sformatf("v%0d_data", i), rf_wdata, vecs[i].ed);
         end
      end

      // Scoreboard set / clear / simultaneous set+clear on register 9
      idle_inputs();
      aux_reg[4:0] = 5'd9; aux_data[31:0] = 32'h00000099;
      sb_set = 1; sb_set_reg = 9; rs = 9;
      pre_phase(); chk("sb_before_set", 32'(rs_busy), 0); post_phase();
      sb_set = 0; aux_req = 2'b01;
      pre_phase(); chk("sb_after_set", 32'(rs_busy), 1);
      chk("sb_grant9", 32'(aux_grant), 32'b01); post_phase();
      aux_req = 0;
      pre_phase(); chk("sb_cleared", 32'(rs_busy), 0); post_phase();
      sb_set = 1;
      pre_phase(); post_phase();
      aux_req = 2'b01;
      pre_phase(); chk("sb_both_grant", 32'(aux_grant), 32'b01); post_phase();
      aux_req = 0; sb_set = 0;
      pre_phase(); chk("sb_set_wins", 32'(rs_busy), 1); post_phase();

      // Reset with pending bits and a queued aux request
      sb_set = 1; sb_set_reg = 12;
      pre_phase(); post_phase();
      sb_set = 0; rs = 9; rt = 12; wb_valid = 1; wb_reg = 7; wb_data = 32'h7777; aux_req = 2'b11;
      pre_phase(); chk("rst_pre_rs", 32'(rs_busy), 1); chk("rst_pre_rt", 32'(rt_busy), 1);
      post_phase();
      Reset = 1;
      pre_phase(); chk("rst_grant", 32'(aux_grant), 0); chk("rst_stall", 32'(wb_stall), 0);
      post_phase();
      chk("rst_drop_we", 32'(rf_we), 0);
      Reset = 0; wb_valid = 0; aux_req = 0;
      pre_phase(); chk("rst_rs_busy", 32'(rs_busy), 0); chk("rst_rt_busy", 32'(rt_busy), 0);
      post_phase();

`ifdef REGFILE_ARB_BYPASS_EN
      wb_valid = 1; wb_reg = 5; wb_data = 32'hA5A5A5A5; rs = 0;
      pre_phase(); post_phase();
      wb_valid = 0; rs = 5;
      pre_phase(); chk("fwd_hit", 32'(rs_fwd_hit), 1); chk("fwd_data", rs_fwd_data, 32'hA5A5A5A5);
      post_phase();
`endif

      // Randomized traffic; aux requests held until granted
      idle_inputs();
      for (int c = 0; c < 400; c++) begin
         Reset = ($urandom_range(99) == 0);
         wb_valid = ($urandom_range(9) < 6);
         wb_reg = 5'($urandom_range(31)); wb_data = $urandom;
         for (int i = 0; i < N; i++)
            if (!aux_req[i] && $urandom_range(2) == 0) begin
               aux_req[i] = 1'b1;
               aux_reg[5*i +: 5] = 5'($urandom_range(7));
               aux_data[32*i +: 32] = $urandom;
            end
         sb_set = ($urandom_range(3) == 0); sb_set_reg = 5'($urandom_range(7));
         rs = 5'($urandom_range(7)); rt = 5'($urandom_range(7));
         pre_phase();
         post_phase();
         if (Reset) aux_req = '0;
         else aux_req = aux_req & ~e_grant;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
